// File: rtl/ahb3lite_pkg.sv
// AHB3-Lite transfer, burst and response encodings shared by interconnect blocks.
// Constants only; no timing or flow-control behaviour of its own.
package ahb3lite_pkg;
    localparam logic [1:0] HTRANS_IDLE   = 2'b00;
    localparam logic [1:0] HTRANS_BUSY   = 2'b01;
    localparam logic [1:0] HTRANS_NONSEQ = 2'b10;
    localparam logic [1:0] HTRANS_SEQ    = 2'b11;

    localparam logic [2:0] HBURST_SINGLE = 3'b000;
    localparam logic [2:0] HBURST_INCR   = 3'b001;
    localparam logic [2:0] HBURST_WRAP4  = 3'b010;
    localparam logic [2:0] HBURST_INCR4  = 3'b011;
    localparam logic [2:0] HBURST_WRAP8  = 3'b100;
    localparam logic [2:0] HBURST_INCR8  = 3'b101;
    localparam logic [2:0] HBURST_WRAP16 = 3'b110;
    localparam logic [2:0] HBURST_INCR16 = 3'b111;

    localparam logic HRESP_OKAY  = 1'b0;
    localparam logic HRESP_ERROR = 1'b1;
endpackage

// File: rtl/ahb3lite_interconnect_slave_arb_if.sv
// Bundle of master-side request buses and slave-side buses around one slave port arbiter.
// slave modport is the arbiter's view; master modport is the surrounding fabric's view.
interface ahb3lite_interconnect_slave_arb_if #(
    parameter int HADDR_SIZE = 32,
    parameter int HDATA_SIZE = 32,
    parameter int MASTERS    = 3
);
    logic [MASTERS-1:0][2:0]            mstpriority;
    logic [MASTERS-1:0]                 mstHSEL;
    logic [MASTERS-1:0]                 can_switch;
    logic [MASTERS-1:0][HADDR_SIZE-1:0] mstHADDR;
    logic [MASTERS-1:0][HDATA_SIZE-1:0] mstHWDATA;
    logic [MASTERS-1:0]                 mstHWRITE;
    logic [MASTERS-1:0][2:0]            mstHSIZE;
    logic [MASTERS-1:0][2:0]            mstHBURST;
    logic [MASTERS-1:0][3:0]            mstHPROT;
    logic [MASTERS-1:0][1:0]            mstHTRANS;
    logic [MASTERS-1:0]                 mstHMASTLOCK;
    logic [MASTERS-1:0]                 mstHREADY;

    logic [MASTERS-1:0]                 master_granted;
    logic [HDATA_SIZE-1:0]              mstHRDATA;
    logic                               mstHREADYOUT;
    logic                               mstHRESP;

    logic                               HSEL;
    logic [HADDR_SIZE-1:0]              HADDR;
    logic [HDATA_SIZE-1:0]              HWDATA;
    logic                               HWRITE;
    logic [2:0]                         HSIZE;
    logic [2:0]                         HBURST;
    logic [3:0]                         HPROT;
    logic [1:0]                         HTRANS;
    logic                               HMASTLOCK;
    logic                               HREADYOUT;
    logic [HDATA_SIZE-1:0]              HRDATA;
    logic                               HREADY;
    logic                               HRESP;

    modport slave (
        input  mstpriority, mstHSEL, can_switch, mstHADDR, mstHWDATA, mstHWRITE,
               mstHSIZE, mstHBURST, mstHPROT, mstHTRANS, mstHMASTLOCK, mstHREADY,
        output master_granted, mstHRDATA, mstHREADYOUT, mstHRESP,
        output HSEL, HADDR, HWDATA, HWRITE, HSIZE, HBURST, HPROT, HTRANS, HMASTLOCK, HREADYOUT,
        input  HRDATA, HREADY, HRESP
    );

    modport master (
        output mstpriority, mstHSEL, can_switch, mstHADDR, mstHWDATA, mstHWRITE,
               mstHSIZE, mstHBURST, mstHPROT, mstHTRANS, mstHMASTLOCK, mstHREADY,
        input  master_granted, mstHRDATA, mstHREADYOUT, mstHRESP,
        input  HSEL, HADDR, HWDATA, HWRITE, HSIZE, HBURST, HPROT, HTRANS, HMASTLOCK, HREADYOUT,
        output HRDATA, HREADY, HRESP
    );
endinterface

// File: rtl/ahb3lite_interconnect_slave_arb_sel.sv
// Highest-priority requester picker, one-hot out, zero latency; ties fixed-low or round-robin
// (AHB3_SLV_ARB_RR_EN). No backpressure: purely combinational.
module ahb3lite_interconnect_slave_arb_sel #(
    parameter int MASTERS = 3,
    parameter int IDX_W   = 2
) (
    input  logic [MASTERS-1:0]      req,
    input  logic [MASTERS-1:0][2:0] prio,
    input  logic [IDX_W-1:0]        ptr,
    output logic [MASTERS-1:0]      gnt,
    output logic                    any
);
    logic [2:0]         max_p;
    logic [MASTERS-1:0] cand;
    logic               found;

`ifndef AHB3_SLV_ARB_RR_EN
    logic unused_ptr;
    assign unused_ptr = ^ptr;
`endif

    assign any = |req;

    always_comb begin
        max_p = '0;
        cand  = '0;
        gnt   = '0;
        found = 1'b0;
        for (int i = 0; i < MASTERS; i++) begin
            if (req[i] && (prio[i] > max_p)) max_p = prio[i];
        end
        for (int i = 0; i < MASTERS; i++) begin
            cand[i] = req[i] && (prio[i] == max_p);
        end
`ifdef AHB3_SLV_ARB_RR_EN
        // search starts just past the last granted master and wraps
        for (int k = 0; k < MASTERS; k++) begin
            int idx;
            idx = (int'(ptr) + 1 + k) % MASTERS;
            if (!found && cand[idx]) begin
                gnt[idx] = 1'b1;
                found    = 1'b1;
            end
        end
`else
        for (int i = 0; i < MASTERS; i++) begin
            if (!found && cand[i]) begin
                gnt[i] = 1'b1;
                found  = 1'b1;
            end
        end
`endif
    end
endmodule

// File: rtl/ahb3lite_interconnect_slave_arb.sv
// Per-slave AHB3-Lite arbiter: grant registered 1 cycle after decision, slave bus muxed combinationally.
// Ownership frozen during wait states (HREADY=0) and locked transfers; macro AHB3_SLV_ARB_RR_EN enables round-robin ties.
module ahb3lite_interconnect_slave_arb
    import ahb3lite_pkg::*;
#(
    parameter int HADDR_SIZE = 32,
    parameter int HDATA_SIZE = 32,
    parameter int MASTERS    = 3
) (
    input logic                            HCLK,
    input logic                            HRESET,
    ahb3lite_interconnect_slave_arb_if.slave bus
);
    localparam int IDX_W = (MASTERS > 1) ? $clog2(MASTERS) : 1;

    logic [MASTERS-1:0]    owner;
    logic [MASTERS-1:0]    sel_gnt;
    logic                  sel_any;
    logic [IDX_W-1:0]      owner_idx;
    logic [IDX_W-1:0]      sel_idx;
    logic [IDX_W-1:0]      data_idx;
    logic [IDX_W-1:0]      rr_ptr;
    logic                  owner_locked;
    logic                  rearb;
    logic                  hsel;
    logic [HADDR_SIZE-1:0] addr_mux;
    logic [HDATA_SIZE-1:0] wdata_mux;

    function automatic logic [IDX_W-1:0] oh2idx(input logic [MASTERS-1:0] oh);
        oh2idx = '0;
        for (int i = 0; i < MASTERS; i++) begin
            if (oh[i]) oh2idx = IDX_W'(i);
        end
    endfunction

    assign owner_idx    = oh2idx(owner);
    assign sel_idx      = oh2idx(sel_gnt);
    assign owner_locked = bus.mstHSEL[owner_idx] & bus.mstHMASTLOCK[owner_idx];
    assign rearb        = bus.HREADY
                        & (~bus.mstHSEL[owner_idx] | bus.can_switch[owner_idx])
                        & ~owner_locked;

    ahb3lite_interconnect_slave_arb_sel #(
        .MASTERS (MASTERS),
        .IDX_W   (IDX_W)
    ) u_sel (
        .req  (bus.mstHSEL),
        .prio (bus.mstpriority),
        .ptr  (rr_ptr),
        .gnt  (sel_gnt),
        .any  (sel_any)
    );

    // with no requester the current owner stays parked on the bus
    always_ff @(posedge HCLK) begin
        if (HRESET) begin
            owner    <= MASTERS'(1);
            data_idx <= '0;
            rr_ptr   <= '0;
        end else begin
            if (rearb && sel_any) begin
                owner <= sel_gnt;
                if (sel_gnt != owner) rr_ptr <= sel_idx;
            end
            if (bus.HREADY) data_idx <= owner_idx;
        end
    end

    assign hsel      = bus.mstHSEL[owner_idx];
    assign addr_mux  = bus.mstHADDR[owner_idx];
    assign wdata_mux = bus.mstHWDATA[data_idx];

    assign bus.master_granted = owner;
    assign bus.HSEL           = hsel;
    assign bus.HADDR          = addr_mux;
    assign bus.HWDATA         = wdata_mux;
    assign bus.HWRITE         = bus.mstHWRITE[owner_idx];
    assign bus.HSIZE          = bus.mstHSIZE[owner_idx];
    assign bus.HBURST         = bus.mstHBURST[owner_idx];
    assign bus.HPROT          = bus.mstHPROT[owner_idx];
    assign bus.HTRANS         = hsel ? bus.mstHTRANS[owner_idx] : HTRANS_IDLE;
    assign bus.HMASTLOCK      = bus.mstHMASTLOCK[owner_idx];
    assign bus.HREADYOUT      = bus.mstHREADY[owner_idx];

    assign bus.mstHRDATA      = bus.HRDATA;
    assign bus.mstHREADYOUT   = bus.HREADY;
    assign bus.mstHRESP       = bus.HRESP;
endmodule

// File: doc/ahb3lite_interconnect_slave_arb.md
AHB3LITE_INTERCONNECT_SLAVE_ARB -- requirements
Module: ahb3lite_interconnect_slave_arb

Interface
REQ-001 SHALL have parameter HADDR_SIZE, default 32, address width.
REQ-002 SHALL have parameter HDATA_SIZE, default 32, data width.
REQ-003 SHALL have parameter MASTERS, default 3, number of requesting master ports.
REQ-004 SHALL have ports: HCLK in 1 clock; HRESET in 1 reset (one clock; reset is synchronous and active-high).
REQ-005 SHALL have ports: mstpriority in [MASTERS][3] per-master priority; mstHSEL in [MASTERS] slave-select request; can_switch in [MASTERS] master may release next cycle.
REQ-006 SHALL have ports: mstHADDR [MASTERS][HADDR_SIZE], mstHWDATA [MASTERS][HDATA_SIZE], mstHWRITE [MASTERS], mstHSIZE/mstHBURST [MASTERS][3], mstHPROT [MASTERS][4], mstHTRANS [MASTERS][2], mstHMASTLOCK [MASTERS], mstHREADY [MASTERS]; all inputs.
REQ-007 SHALL have outputs: master_granted [MASTERS] one-hot grant; mstHRDATA HDATA_SIZE; mstHREADYOUT 1; mstHRESP 1; all broadcast to every master port.
REQ-008 SHALL have slave-side outputs HSEL, HADDR, HWDATA, HWRITE, HSIZE, HBURST, HPROT, HTRANS, HMASTLOCK, HREADYOUT (drives slave HREADY); inputs HRDATA, HREADY (slave HREADYOUT), HRESP.

Function
REQ-009 SHALL keep a one-hot address-phase owner register; master_granted equals it.
REQ-010 SHALL re-arbitrate when HREADY=1 and (owner mstHSEL=0 or can_switch[owner]=1) and owner not locked (mstHSEL & mstHMASTLOCK of owner).
REQ-011 SHALL select, on re-arbitration, the requester (mstHSEL=1) with the highest mstpriority; no requester keeps current owner (parking).
REQ-012 SHALL resolve equal-priority ties to lowest index unless REQ-024 applies.
REQ-013 SHALL register the new owner: grant visible on master_granted one cycle after the decision cycle.
REQ-014 SHALL drive HADDR, HWRITE, HSIZE, HBURST, HPROT, HMASTLOCK combinationally from owner's inputs.
REQ-015 SHALL drive HSEL=mstHSEL[owner] and HTRANS=mstHTRANS[owner] when HSEL=1, else HTRANS=IDLE.
REQ-016 SHALL drive HREADYOUT=mstHREADY[owner].
REQ-017 SHALL keep a data-phase owner register loaded with the address owner when HREADY=1; HWDATA muxed by data-phase owner.
REQ-018 SHALL pass HRDATA, HREADY, HRESP unchanged to mstHRDATA, mstHREADYOUT, mstHRESP.
REQ-019 SHALL never change owner while HREADY=0 (wait state), including when can_switch asserts.
REQ-020 SHALL assert exactly one master_granted bit at all times.

Reset
REQ-021 SHALL on HRESET=1 at HCLK edge set owner and data-phase owner to master 0 (master_granted=1), round-robin pointer to 0.
REQ-022 SHALL, after reset, output HSEL=mstHSEL[0] and HTRANS IDLE unless master 0 requests; reset mid-transfer abandons it with no further grant change that cycle.

Configuration
REQ-023 SHALL use macro AHB3_SLV_ARB_RR_EN.
REQ-024 SHALL, with AHB3_SLV_ARB_RR_EN defined, break equal-priority ties round-robin starting at index after last granted master; pointer updates on each grant change. Without it, REQ-012 fixed lowest-index.

Structure
REQ-025 SHALL import HTRANS_*, HBURST_*, HRESP_* from ahb3lite_pkg; no new package types.
REQ-026 SHALL place priority/tie selection in sub-module ahb3lite_interconnect_slave_arb_sel (combinational, request/priority/pointer in, one-hot out).

Verification
REQ-027 Single requester master 2, NONSEQ SINGLE, HREADY=1 -> master_granted 001->100 next cycle, HSEL=1, HADDR=master 2 address.
REQ-028 Masters 0 (prio 1) and 1 (prio 5) request with owner can_switch=1 -> master_granted=010.
REQ-029 Owner master 0 mstHMASTLOCK=1, master 1 prio 7 requesting -> grant stays 001 until lock drops.
REQ-030 HREADY=0 for 3 cycles with higher-priority request -> grant unchanged; switches the cycle after HREADY=1.
REQ-031 RR_EN: masters 0,1,2 equal prio continuously, can_switch=1 -> grants 010,100,001 sequence; without macro -> stays 001.
REQ-032 Write from master 1 then switch to master 2 -> HWDATA carries master 1 data during master 2 address phase; HRESET mid-burst -> master_granted=001 next cycle.
